muldiv_sequencer: RTL



---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_sequencer_div_restore_step.sv | 28 ++
 rtl/muldiv_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: state
// encoding, default sizing and the R-type funct codes decoded by the control unit.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_CNT_W = 6;
   localparam int MD_ITERS = MD_WIDTH;

   localparam logic [5:0] MULT = 6'h18;
   localparam logic [5:0] DIV  = 6'h1a;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MULT_RUN = 3'd1,
      DIV_CHK  = 3'd2,
      DIV_RUN  = 3'd3,
      DIV_FIX  = 3'd4,
      FINISH   = 3'd5
   } md_state_t;

endpackage

// File: rtl/muldiv_sequencer_div_restore_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder, subtract the divisor if it fits, and shift
// the resulting quotient bit into the low end of the quotient register.
module div_restore_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] sub;
   logic             fits;

   // trial subtraction; the partial remainder stays below the divisor, so the
   // difference always fits in WIDTH bits whenever the subtraction is kept
   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      fits    = (shifted >= {1'b0, divisor});
      sub     = shifted[WIDTH-1:0] - divisor;
      rem_out = fits ? sub : shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit owning HI/LO. Multiply is radix-2
// Booth (WIDTH steps); divide is restoring division on magnitudes (WIDTH steps)
// followed by a sign-fix cycle. Status outputs are registered so that busy,
// done and div_by_zero line up with the cycle in which hi/lo are updated.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = MD_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_t        state_reg, state_next;

   // acc holds the Booth upper half (one guard bit) or the division remainder;
   // q holds the multiplier / dividend, later the product low half / quotient
   logic [WIDTH:0]   acc_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] m_reg;
   logic             qm1_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             sign_a_reg, sign_b_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic             busy_reg, done_reg, dbz_reg;
   logic             busy_next, done_next, dbz_next;

   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH-1:0] div_rem, div_quo;
   logic             last_step;

   assign m_ext     = {m_reg[WIDTH-1], m_reg};
   assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

   div_restore_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (acc_reg[WIDTH-1:0]),
      .quo_in  (q_reg),
      .divisor (m_reg),
      .rem_out (div_rem),
      .quo_out (div_quo)
   );

   // Booth recoding of the current multiplier bit pair: add, subtract or pass
   always_comb begin
      booth_sum = acc_reg;
      case ({q_reg[0], qm1_reg})
         2'b01:   booth_sum = acc_reg + m_ext;
         2'b10:   booth_sum = acc_reg - m_ext;
         default: booth_sum = acc_reg;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // next-state logic; multiply takes priority when both starts are raised
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start_mult)     state_next = MULT_RUN;
            else if (start_div) state_next = DIV_CHK;
         end
         MULT_RUN: if (last_step) state_next = FINISH;
         DIV_CHK:  state_next = (m_reg == '0) ? IDLE : DIV_RUN;
         DIV_RUN:  if (last_step) state_next = DIV_FIX;
         DIV_FIX:  state_next = FINISH;
         FINISH:   state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // status outputs for the following cycle, derived from the current state
   always_comb begin
      busy_next = (state_reg != IDLE);
      done_next = (state_reg == FINISH);
      dbz_next  = (state_reg == DIV_CHK) && (m_reg == '0);
   end

   // registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
         dbz_reg  <= 1'b0;
      end else begin
         busy_reg <= busy_next;
         done_reg <= done_next;
         dbz_reg  <= dbz_next;
      end
   end

   // datapath: operand latch, Booth/divide iterations, sign fix, HI/LO write
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg    <= '0;
         q_reg      <= '0;
         m_reg      <= '0;
         qm1_reg    <= 1'b0;
         cnt_reg    <= '0;
         sign_a_reg <= 1'b0;
         sign_b_reg <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (start_mult || start_div) begin
                  acc_reg <= '0;
                  q_reg   <= op_a;
                  m_reg   <= op_b;
                  qm1_reg <= 1'b0;
               end
            end
            MULT_RUN: begin
               acc_reg <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
               q_reg   <= {booth_sum[0], q_reg[WIDTH-1:1]};
               qm1_reg <= q_reg[0];
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
            DIV_CHK: begin
               // magnitudes as unsigned WIDTH-bit values; the most negative
               // operand maps to 2^(WIDTH-1), which still fits unsigned
               sign_a_reg <= q_reg[WIDTH-1];
               sign_b_reg <= m_reg[WIDTH-1];
               q_reg      <= q_reg[WIDTH-1] ? -q_reg : q_reg;
               m_reg      <= m_reg[WIDTH-1] ? -m_reg : m_reg;
               acc_reg    <= '0;
               cnt_reg    <= '0;
            end
            DIV_RUN: begin
               acc_reg <= {1'b0, div_rem};
               q_reg   <= div_quo;
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
            DIV_FIX: begin
               q_reg   <= (sign_a_reg ^ sign_b_reg) ? -q_reg : q_reg;
               acc_reg <= {1'b0, sign_a_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]};
            end
            FINISH: begin
               hi_reg <= acc_reg[WIDTH-1:0];
               lo_reg <= q_reg;
            end
            default: ;
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign div_by_zero = dbz_reg;
   assign hi          = hi_reg;
   assign lo          = lo_reg;

endmodule
